// File: rtl/merge_run_feeder.sv
// rtl/merge_run_feeder.sv - ping-pong run buffer feeding two sorted run heads to a serial merge node
//
// Purpose:
//   Loads pairs of sorted runs (A then B, 2*RUN_LEN words) from a word-serial
//   stream into one of two banks, and drains a full bank by presenting the
//   current A and B heads to a merge node. The merge node reports which head
//   it consumed on ctrl_addr. The all-ones word marks an exhausted run.
//
// Ports:
//   clk        clock, all logic on posedge
//   rst        asynchronous active-high reset
//   in_valid   input word valid
//   in_data    sorted input word, strictly below all-ones
//   in_ready   feeder can accept in_data this cycle
//   ctrl_addr  1 = B head consumed, 0 = A head consumed (used only while draining)
//   outA       current run-A head, or all-ones
//   outB       current run-B head, or all-ones
//   out_valid  high while a bank is being drained
//   start_out  one-cycle pulse on the first cycle a bank's heads are presented
module merge_run_feeder #(
  parameter int DATA_WIDTH = 32,
  parameter int RUN_LEN    = 8,
  parameter int CNT_WIDTH  = $clog2(RUN_LEN) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  input  logic                  ctrl_addr,
  output logic [DATA_WIDTH-1:0] outA,
  output logic [DATA_WIDTH-1:0] outB,
  output logic                  out_valid,
  output logic                  start_out
);

  localparam int BANK_WORDS = 2 * RUN_LEN;
  localparam logic [DATA_WIDTH-1:0] SENTINEL = '1;
  localparam logic [CNT_WIDTH-1:0]  LAST_IDX = CNT_WIDTH'(BANK_WORDS - 1);
  localparam logic [CNT_WIDTH-1:0]  RUN_END  = CNT_WIDTH'(RUN_LEN);
  localparam logic [CNT_WIDTH-1:0]  ONE      = CNT_WIDTH'(1);

  typedef enum logic {IDLE, DRAIN} state_t;

  // Each bank stores run A at [0, RUN_LEN) and run B at [RUN_LEN, 2*RUN_LEN),
  // so the load counter doubles as the linear write address.
  logic [DATA_WIDTH-1:0] mem [2][BANK_WORDS];

  state_t               state;
  logic                 wb;
  logic                 rb;
  logic [1:0]           bank_full;
  logic [1:0]           full_nxt;
  logic [CNT_WIDTH-1:0] wcnt;
  logic [CNT_WIDTH-1:0] dcnt;
  logic [CNT_WIDTH-1:0] ptr_a;
  logic [CNT_WIDTH-1:0] ptr_b;
  logic                 load;
  logic                 load_done;
  logic                 drain_done;
  logic                 rb_other;

  assign in_ready   = !bank_full[wb];
  assign load       = in_valid && in_ready;
  assign load_done  = load && (wcnt == LAST_IDX);
  assign drain_done = (state == DRAIN) && (dcnt == LAST_IDX);
  assign rb_other   = ~rb;
  assign out_valid  = (state == DRAIN);

  // Next-cycle full flags; the drain side looks at this so a bank that
  // completes on the same edge as the current drain is picked up with no bubble.
  // Set and clear never hit the same bank: loading requires bank_full[wb]=0.
  always_comb begin
    full_nxt = bank_full;
    if (load_done)  full_nxt[wb] = 1'b1;
    if (drain_done) full_nxt[rb] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (load) mem[wb][wcnt] <= in_data;
  end

  // Heads are combinational reads of the array; an exhausted run shows all-ones.
  always_comb begin
    outA = SENTINEL;
    outB = SENTINEL;
    if (state == DRAIN) begin
      if (ptr_a != RUN_END) outA = mem[rb][{1'b0, ptr_a[CNT_WIDTH-2:0]}];
      if (ptr_b != RUN_END) outB = mem[rb][{1'b1, ptr_b[CNT_WIDTH-2:0]}];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      wb        <= 1'b0;
      rb        <= 1'b0;
      bank_full <= 2'b00;
      wcnt      <= '0;
      dcnt      <= '0;
      ptr_a     <= '0;
      ptr_b     <= '0;
      start_out <= 1'b0;
    end else begin
      bank_full <= full_nxt;
      start_out <= 1'b0;

      if (load) begin
        if (wcnt == LAST_IDX) begin
          wb   <= ~wb;
          wcnt <= '0;
        end else begin
          wcnt <= wcnt + ONE;
        end
      end

      case (state)
        IDLE: begin
          if (bank_full[rb]) begin
            state     <= DRAIN;
            ptr_a     <= '0;
            ptr_b     <= '0;
            dcnt      <= '0;
            start_out <= 1'b1;
          end
        end
        DRAIN: begin
          // An exhausted side never advances, even if ctrl_addr points at it.
          if (!ctrl_addr && ptr_a != RUN_END) ptr_a <= ptr_a + ONE;
          if (ctrl_addr && ptr_b != RUN_END)  ptr_b <= ptr_b + ONE;
          dcnt <= dcnt + ONE;
          if (dcnt == LAST_IDX) begin
            rb <= rb_other;
            if (full_nxt[rb_other]) begin
              ptr_a     <= '0;
              ptr_b     <= '0;
              dcnt      <= '0;
              start_out <= 1'b1;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_merge_run_feeder.sv
// tb/tb_merge_run_feeder.sv - directed table-driven bench for merge_run_feeder with RUN_LEN=4
module tb_merge_run_feeder;

  localparam int DW = 32;
  localparam int RL = 4;
  localparam logic [31:0] ONES = 32'hFFFF_FFFF;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          ctrl_addr = 1'b0;
  logic [DW-1:0] outA;
  logic [DW-1:0] outB;
  logic          out_valid;
  logic          start_out;

  merge_run_feeder #(.DATA_WIDTH(DW), .RUN_LEN(RL)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .ctrl_addr (ctrl_addr),
    .outA      (outA),
    .outB      (outB),
    .out_valid (out_valid),
    .start_out (start_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0][31:0] words;  // stream order: A0..A3, B0..B3
    logic [7:0][31:0] exp;    // merged output order
  } vec_t;

  vec_t tv[3];
  int   total = 0;
  int   bad = 0;

  function automatic logic [7:0][31:0] pack8(input int x0, x1, x2, x3, x4, x5, x6, x7);
    logic [7:0][31:0] r;
    r[0] = x0; r[1] = x1; r[2] = x2; r[3] = x3;
    r[4] = x4; r[5] = x5; r[6] = x6; r[7] = x7;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Starts and ends just after a posedge.
  task automatic load_bank(input logic [7:0][31:0] w, input string tag);
    for (int i = 0; i < 8; i++) begin
      in_valid = 1'b1;
      in_data  = w[i];
      @(negedge clk);
      chk($sformatf("%s in_ready word%0d", tag, i), in_ready, 1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic run_vector(input int idx, input string tag);
    int pa, pb;
    logic [31:0] ea, eb, rec;
    load_bank(tv[idx].words, tag);
    @(negedge clk);
    chk({tag, " idle out_valid"}, out_valid, 0);
    chk({tag, " idle start_out"}, start_out, 0);
    pa = 0; pb = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      ea = (pa < RL) ? tv[idx].words[pa] : ONES;
      eb = (pb < RL) ? tv[idx].words[RL + pb] : ONES;
      chk($sformatf("%s c%0d out_valid", tag, c), out_valid, 1);
      chk($sformatf("%s c%0d start_out", tag, c), start_out, (c == 0) ? 1 : 0);
      chk($sformatf("%s c%0d outA", tag, c), outA, ea);
      chk($sformatf("%s c%0d outB", tag, c), outB, eb);
      rec = (outA > outB) ? outB : outA;
      chk($sformatf("%s c%0d merged", tag, c), rec, tv[idx].exp[c]);
      ctrl_addr = (ea > eb);
      if (ea > eb) pb++; else pa++;
    end
    @(negedge clk);
    chk({tag, " end out_valid"}, out_valid, 0);
    chk({tag, " end outA"}, outA, ONES);
    chk({tag, " end outB"}, outB, ONES);
    ctrl_addr = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    int sent, got, low_cnt, low_sent, fill1, fill3, last_valid, nstart;
    int starts[3];
    logic acc;
    logic [31:0] rec;

    tv[0].words = pack8(1, 3, 5, 7, 2, 4, 6, 8);
    tv[0].exp   = pack8(1, 2, 3, 4, 5, 6, 7, 8);
    tv[1].words = pack8(1, 2, 3, 4, 5, 6, 7, 8);
    tv[1].exp   = pack8(1, 2, 3, 4, 5, 6, 7, 8);
    tv[2].words = pack8(2, 2, 9, 9, 2, 3, 9, 10);
    tv[2].exp   = pack8(2, 2, 2, 3, 9, 9, 9, 10);

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst in_ready", in_ready, 1);
    chk("rst out_valid", out_valid, 0);
    chk("rst start_out", start_out, 0);
    chk("rst outA", outA, ONES);
    chk("rst outB", outB, ONES);
    rst = 1'b0;
    @(posedge clk); #1;

    // Basic merge, exhaustion, ties
    for (int v = 0; v < 3; v++) run_vector(v, $sformatf("vec%0d", v));

    // Ping-pong streaming with backpressure and back-to-back drains
    sent = 0; got = 0; low_cnt = 0; low_sent = -1; fill1 = -1; fill3 = -1;
    last_valid = -1; nstart = 0;
    for (int i = 0; i < 3; i++) starts[i] = -1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (start_out) begin
        if (nstart < 3) starts[nstart] = cyc;
        nstart++;
      end
      if (out_valid) begin
        rec = (outA > outB) ? outB : outA;
        chk($sformatf("pp merged%0d", got), rec, got + 1);
        got++;
        last_valid = cyc;
        ctrl_addr = (outA > outB);
      end else begin
        ctrl_addr = 1'b0;
      end
      in_valid = (sent < 24);
      in_data  = 32'((sent / 8) * 8 + ((sent % 8) < 4 ? 2 * (sent % 8) + 1 : 2 * (sent % 8 - 4) + 2));
      if (in_valid && !in_ready) begin
        if (low_cnt == 0) low_sent = sent;
        low_cnt++;
      end
      acc = in_valid && in_ready;
      @(posedge clk); #1;
      if (acc) begin
        sent++;
        if (sent == 8)  fill1 = cyc;
        if (sent == 24) fill3 = cyc;
      end
    end
    in_valid = 1'b0;
    ctrl_addr = 1'b0;
    chk("pp words merged", got, 24);
    chk("pp backpressure at", low_sent, 16);
    chk("pp backpressure cycles", low_cnt, 1);
    chk("pp start count", nstart, 3);
    chk("pp first start latency", starts[0], fill1 + 2);
    chk("pp start gap 1", starts[1] - starts[0], 8);
    chk("pp start gap 2", starts[2] - starts[1], 8);
    chk("pp back-to-back start", starts[2], fill3 + 1);
    chk("pp contiguous drain", last_valid - starts[0], 23);

    // Reset in the middle of a drain
    load_bank(tv[0].words, "rst_mid");
    @(negedge clk);
    @(negedge clk); ctrl_addr = 1'b0;   // consume 1 (A)
    @(negedge clk); ctrl_addr = 1'b1;   // consume 2 (B)
    @(negedge clk); ctrl_addr = 1'b0;   // consume 3 (A)
    @(negedge clk);
    chk("rst_mid outA before", outA, 5);
    chk("rst_mid outB before", outB, 4);
    rst = 1'b1;
    ctrl_addr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst_mid out_valid", out_valid, 0);
    chk("rst_mid in_ready", in_ready, 1);
    chk("rst_mid start_out", start_out, 0);
    chk("rst_mid outA", outA, ONES);
    chk("rst_mid outB", outB, ONES);
    rst = 1'b0;
    @(posedge clk); #1;
    run_vector(0, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/merge_run_feeder.md
Name: merge_run_feeder

Overview:
- Source end of the serial-merge data/ctrl_addr interface: buffers two sorted runs (A, B) and presents their heads on outA/outB to a serial merge node.
- The merge node's comparator result (ctrl_addr) tells the feeder which head was consumed; the feeder advances that head.
- Sits in front of the first merge stage of a merge tree. Loads runs from a word-serial input stream into a ping-pong pair of banks, so loading overlaps draining.

Parameters:
DATA_WIDTH, 32, word width; all-ones (2^DATA_WIDTH-1) is reserved as the exhausted-run sentinel.
RUN_LEN, 8, words per run (power of 2, >=2); one bank holds run A plus run B = 2*RUN_LEN words.
CNT_WIDTH, $clog2(RUN_LEN)+1, width of head pointers and counters.

Ports:
clk  input  1  clock, all logic on posedge.
rst  input  1  asynchronous, active-high reset.
in_valid  input  1  input word valid.
in_data  input  DATA_WIDTH  sorted input word; must be < all-ones.
in_ready  output  1  feeder can accept in_data this cycle.
ctrl_addr  input  1  from merge node: 1 = B head consumed, 0 = A head consumed; sampled only while out_valid=1.
outA  output  DATA_WIDTH  current run-A head, or all-ones.
outB  output  DATA_WIDTH  current run-B head, or all-ones.
out_valid  output  1  high while draining (state DRAIN).
start_out  output  1  one-cycle pulse, registered, on the first cycle a bank's heads are presented.

Behaviour:
- Reset values:
  - in_ready=1, out_valid=0, start_out=0, outA=outB=all-ones.
  - wb=rb=0, bank_full=2'b00, wcnt=0, ptrA=ptrB=0, dcnt=0, state=IDLE.
  - Reset mid-operation discards all buffered data; the array contents need no reset.
- Load side:
  - in_ready = !bank_full[wb].
  - A transfer occurs when in_valid && in_ready. Word wcnt goes to bank wb: wcnt<RUN_LEN goes to run A[wcnt]; otherwise run B[wcnt-RUN_LEN].
  - On the transfer with wcnt==2*RUN_LEN-1: set bank_full[wb], toggle wb, wcnt<=0. Otherwise wcnt<=wcnt+1.
  - No transfer means no change.
- Drain FSM, states IDLE and DRAIN:
  - IDLE:
    - If bank_full[rb]: go to DRAIN, ptrA<=0, ptrB<=0, dcnt<=0, start_out<=1 next cycle.
    - A bank that becomes full this cycle is seen next cycle, so a fill-to-drain takes 1 idle cycle.
  - DRAIN:
    - out_valid=1.
    - outA = (ptrA==RUN_LEN) ? all-ones : A[rb][ptrA]. outA is a combinational read of the register array.
    - outB is formed the same way from ptrB and run B.
    - Each cycle: if ctrl_addr==0 and ptrA<RUN_LEN then ptrA++. If ctrl_addr==1 and ptrB<RUN_LEN then ptrB++.
    - An exhausted side never advances, even on an illegal ctrl_addr.
    - dcnt++ every cycle.
    - At dcnt==2*RUN_LEN-1, the last consumption:
      - Clear bank_full[rb] and toggle rb.
      - If the other bank is full, evaluated including a set occurring this same cycle: stay in DRAIN, reset ptrA/ptrB/dcnt, pulse start_out next cycle. Back-to-back drains have zero bubble.
      - Else go to IDLE.
- Simultaneous events:
  - Load completion on wb and drain completion on rb in the same cycle touch different banks; both take effect.
  - Clear on rb and set on wb never target the same bank, because bank_full[wb]=0 is required to load.
- Latency:
  - ctrl_addr sampled at edge N changes outA/outB in the cycle after edge N.
  - One merged word per cycle; a bank drains in exactly 2*RUN_LEN cycles.
- IDLE: outA=outB=all-ones, ctrl_addr ignored.

Test Plan:
1. RUN_LEN=4, load 1,3,5,7,2,4,6,8; bench models ctrl_addr=(outA>outB) and records the min each cycle.
   -> in_ready stays 1; start_out pulses once, 1 cycle after the 8th load edge; records are 1..8 over 8 cycles; then out_valid=0 and outA=outB=FFFFFFFF.
2. Exhaustion: A=1,2,3,4, B=5,6,7,8.
   -> cycles 0-3 ctrl_addr=0; cycles 4-7 outA=FFFFFFFF, ctrl_addr=1; ptrA holds at 4; output is 1..8.
3. Tie handling: A=2,2,9,9, B=2,3,9,10.
   -> A is consumed on each tie; output is 2,2,2,3,9,9,9,10.
4. Ping-pong and backpressure: stream 24 words continuously while draining.
   -> in_ready drops after 16 words buffered; two start_out pulses exactly 8 cycles apart; third bank drains after the first frees.
5. Back-to-back: second bank completes on the same cycle the first drain ends.
   -> DRAIN continues with no IDLE cycle and start_out pulses next cycle.
6. Assert rst at dcnt=3.
   -> next cycle out_valid=0, in_ready=1, start_out=0, outA=FFFFFFFF; a subsequent clean load reproduces scenario 1.
